wb_bus_arbiter: RTL and testbench
=================================

WB_BUS_ARBITER -- requirements
Module: wb_bus_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: width of every Wishbone address port.
REQ-002 Parameter DATA_WIDTH, default 32: width of every Wishbone data port; select width is DATA_WIDTH/8.
REQ-003 Parameter TIMEOUT_CYCLES, default 255: cycles without ack before abort (used only with WB_ARB_TIMEOUT_EN).
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 mN_wb_cyc_i / mN_wb_stb_i (N=0 instruction fetch, N=1 data)  input  1 each  master N cycle/strobe request.
REQ-007 mN_wb_adr_i  input  ADDR_WIDTH;  mN_wb_dat_i  input  DATA_WIDTH;  mN_wb_sel_i  input  DATA_WIDTH/8;  mN_wb_we_i  input  1  master N request fields.
REQ-008 mN_wb_ack_o  output  1  ack to master N; mN_wb_err_o  output  1  timeout error to master N.
REQ-009 mN_wb_dat_o  output  DATA_WIDTH  read data to master N.
REQ-010 s_wb_cyc_o, s_wb_stb_o, s_wb_we_o  output  1;  s_wb_adr_o  output  ADDR_WIDTH;  s_wb_dat_o  output  DATA_WIDTH;  s_wb_sel_o  output  DATA_WIDTH/8  shared slave port.
REQ-011 s_wb_ack_i  input  1;  s_wb_dat_i  input  DATA_WIDTH  slave response.

Function
REQ-012 FSM SHALL have states IDLE, GNT0, GNT1; one registered grant owner at a time.
REQ-013 IDLE: if exactly one mN_wb_cyc_i is high, SHALL move to GNTN next edge.
REQ-014 IDLE with both cyc high: SHALL grant the master not recorded in last_grant (round-robin), then update last_grant to the winner.
REQ-015 Arbitration latency: slave port SHALL see the winner's request on the cycle after the decision edge (1-cycle grant latency, zero-cycle pass-through thereafter).
REQ-016 In GNTN, s_wb_* outputs SHALL combinationally mirror master N's cyc/stb/adr/dat/sel/we; non-granted master's signals SHALL be ignored.
REQ-017 mN_wb_ack_o SHALL equal s_wb_ack_i AND (state==GNTN); the non-granted ack SHALL be 0.
REQ-018 m0_wb_dat_o and m1_wb_dat_o SHALL both carry s_wb_dat_i unconditionally.
REQ-019 In GNTN, a cycle with s_wb_ack_i high SHALL return FSM to IDLE next edge (one dead cycle between transactions; no bus parking).
REQ-020 In GNTN, mN_wb_cyc_i dropping without ack (abort) SHALL return FSM to IDLE next edge.
REQ-021 In IDLE all s_wb_* outputs SHALL be 0.
REQ-022 A master holding cyc high across its own ack SHALL re-arbitrate in IDLE like any new request (prevents starvation).

Reset
REQ-023 Asserting reset SHALL immediately force IDLE, last_grant=1 (so m0 wins the first tie), timeout counter=0.
REQ-024 During reset all outputs SHALL be 0, including mid-transaction (slave cyc/stb drop in the same cycle).
REQ-025 First arbitration SHALL occur on the first rising edge after reset deasserts.

Configuration
REQ-026 Macro WB_ARB_TIMEOUT_EN defined: an 8-bit counter SHALL clear on grant entry and increment each GNTN cycle without ack; reaching TIMEOUT_CYCLES SHALL pulse mN_wb_err_o for one cycle, drop s_wb_cyc_o/stb_o, and return to IDLE.
REQ-027 Macro undefined: no counter logic; mN_wb_err_o SHALL be tied 0; a GNTN state waits indefinitely for ack or cyc drop.

Verification
REQ-028 Only m1 requests adr 0x8000_0100 write, slave acks 2 cycles later -> s_wb_adr_o=0x8000_0100, m1_wb_ack_o pulses once, m0_wb_ack_o stays 0.
REQ-029 Both request in same cycle after reset -> m0 granted first; m1 granted after m0's ack plus one IDLE cycle.
REQ-030 Both hold cyc continuously for 6 transactions, slave acks each in 1 cycle -> grants alternate m0,m1,m0,m1,m0,m1.
REQ-031 m0 granted, reset asserted before ack -> s_wb_cyc_o=0 in same cycle; after release m0 re-granted first.
REQ-032 m1 drops cyc in GNT1 with no ack -> IDLE next edge, no ack to either master.
REQ-033 WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, slave never acks m0 -> m0_wb_err_o pulses one cycle after 4 cycles in GNT0, s_wb_cyc_o drops, FSM IDLE.

Source files
------------

// File: rtl/wb_bus_arbiter_if.sv
// Bundle of every Wishbone signal around wb_bus_arbiter: two master-side
// request ports (m0 = instruction fetch, m1 = data) and one shared slave port.
//
// Handshake: a master raises cyc (bus ownership) and stb (transfer strobe).
// It holds adr/dat/sel/we stable until the slave returns ack for that cycle.
// Dropping cyc before ack aborts the transfer.
// ack and err are single-cycle pulses back to the granted master only.
//
// Modport "slave" is the arbiter's own view: it sinks the master requests and
// drives the shared slave port. Modport "master" is the view of the environment
// around the arbiter.
interface wb_bus_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // master 0 (instruction fetch)
  logic                    m0_wb_cyc_i;
  logic                    m0_wb_stb_i;
  logic [ADDR_WIDTH-1:0]   m0_wb_adr_i;
  logic [DATA_WIDTH-1:0]   m0_wb_dat_i;
  logic [DATA_WIDTH/8-1:0] m0_wb_sel_i;
  logic                    m0_wb_we_i;
  logic                    m0_wb_ack_o;
  logic                    m0_wb_err_o;
  logic [DATA_WIDTH-1:0]   m0_wb_dat_o;
  // master 1 (data)
  logic                    m1_wb_cyc_i;
  logic                    m1_wb_stb_i;
  logic [ADDR_WIDTH-1:0]   m1_wb_adr_i;
  logic [DATA_WIDTH-1:0]   m1_wb_dat_i;
  logic [DATA_WIDTH/8-1:0] m1_wb_sel_i;
  logic                    m1_wb_we_i;
  logic                    m1_wb_ack_o;
  logic                    m1_wb_err_o;
  logic [DATA_WIDTH-1:0]   m1_wb_dat_o;
  // shared slave port
  logic                    s_wb_cyc_o;
  logic                    s_wb_stb_o;
  logic                    s_wb_we_o;
  logic [ADDR_WIDTH-1:0]   s_wb_adr_o;
  logic [DATA_WIDTH-1:0]   s_wb_dat_o;
  logic [DATA_WIDTH/8-1:0] s_wb_sel_o;
  logic                    s_wb_ack_i;
  logic [DATA_WIDTH-1:0]   s_wb_dat_i;

  modport slave (
    input  m0_wb_cyc_i, m0_wb_stb_i, m0_wb_adr_i, m0_wb_dat_i, m0_wb_sel_i, m0_wb_we_i,
    output m0_wb_ack_o, m0_wb_err_o, m0_wb_dat_o,
    input  m1_wb_cyc_i, m1_wb_stb_i, m1_wb_adr_i, m1_wb_dat_i, m1_wb_sel_i, m1_wb_we_i,
    output m1_wb_ack_o, m1_wb_err_o, m1_wb_dat_o,
    output s_wb_cyc_o, s_wb_stb_o, s_wb_we_o, s_wb_adr_o, s_wb_dat_o, s_wb_sel_o,
    input  s_wb_ack_i, s_wb_dat_i
  );

  modport master (
    output m0_wb_cyc_i, m0_wb_stb_i, m0_wb_adr_i, m0_wb_dat_i, m0_wb_sel_i, m0_wb_we_i,
    input  m0_wb_ack_o, m0_wb_err_o, m0_wb_dat_o,
    output m1_wb_cyc_i, m1_wb_stb_i, m1_wb_adr_i, m1_wb_dat_i, m1_wb_sel_i, m1_wb_we_i,
    input  m1_wb_ack_o, m1_wb_err_o, m1_wb_dat_o,
    input  s_wb_cyc_o, s_wb_stb_o, s_wb_we_o, s_wb_adr_o, s_wb_dat_o, s_wb_sel_o,
    output s_wb_ack_i, s_wb_dat_i
  );
endinterface

// File: rtl/wb_bus_arbiter.sv
// Two-master round-robin Wishbone arbiter driving a single slave port.
// The FSM (IDLE/GNT0/GNT1) grants one master at a time. After the decision
// edge, the winner's request passes straight through to the slave port.
// Every transaction (ack or abort) returns to IDLE for one dead cycle. There
// is no bus parking, so a master that keeps cyc high re-arbitrates against the
// other master.
//
// Optional feature macro: WB_ARB_TIMEOUT_EN. When it is defined, an 8-bit
// counter aborts a grant that has waited TIMEOUT_CYCLES cycles without ack.
// It then pulses the owner's err output for one cycle. Without the macro,
// err is tied low and a grant waits for ack or for cyc to drop.
//
// o_dbg_state exposes the FSM state: 0 = IDLE, 1 = GNT0, 2 = GNT1.
module wb_bus_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             reset,
  wb_bus_arbiter_if.slave  bus,
  output logic [1:0]       o_dbg_state
);

  localparam int SEL_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t r_state;
  // Master granted most recently; on a tie the other one wins.
  logic   r_last_grant;

  logic                  w_gnt0;
  logic                  w_gnt1;
  logic                  w_pick0;
  logic                  w_pick1;
  logic                  w_own_cyc;

  logic                  w_s_cyc;
  logic                  w_s_stb;
  logic                  w_s_we;
  logic [ADDR_WIDTH-1:0] w_s_adr;
  logic [DATA_WIDTH-1:0] w_s_dat;
  logic [SEL_WIDTH-1:0]  w_s_sel;

`ifdef WB_ARB_TIMEOUT_EN
  // A grant is aborted on its TIMEOUT_CYCLES-th ack-less cycle.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] r_tmo_cnt;
  logic       r_err0;
  logic       r_err1;
`else
  // The timeout length only matters when the counter is built.
  logic       w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYCLES != 0);
`endif

  assign w_gnt0 = (r_state == GNT0);
  assign w_gnt1 = (r_state == GNT1);

  // cyc of the master that currently owns the bus (0 in IDLE)
  assign w_own_cyc = (w_gnt0 & bus.m0_wb_cyc_i) | (w_gnt1 & bus.m1_wb_cyc_i);

  // IDLE decision: a lone requester wins, a tie goes to the master not granted last
  always_comb begin
    w_pick0 = 1'b0;
    w_pick1 = 1'b0;
    if (bus.m0_wb_cyc_i && bus.m1_wb_cyc_i) begin
      w_pick0 = r_last_grant;
      w_pick1 = !r_last_grant;
    end else begin
      w_pick0 = bus.m0_wb_cyc_i;
      w_pick1 = bus.m1_wb_cyc_i;
    end
  end

  // Grant FSM with registered grant owner, round-robin pointer and timeout state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
`ifdef WB_ARB_TIMEOUT_EN
      r_tmo_cnt    <= 8'd0;
      r_err0       <= 1'b0;
      r_err1       <= 1'b0;
`endif
    end else begin
`ifdef WB_ARB_TIMEOUT_EN
      r_err0 <= 1'b0;
      r_err1 <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_pick0) begin
            r_state      <= GNT0;
            r_last_grant <= 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
            r_tmo_cnt    <= 8'd0;
`endif
          end else if (w_pick1) begin
            r_state      <= GNT1;
            r_last_grant <= 1'b1;
`ifdef WB_ARB_TIMEOUT_EN
            r_tmo_cnt    <= 8'd0;
`endif
          end
        end
        GNT0, GNT1: begin
          // ack ends the transfer; cyc dropping without ack is an abort
          if (bus.s_wb_ack_i || !w_own_cyc) begin
            r_state <= IDLE;
`ifdef WB_ARB_TIMEOUT_EN
          end else if (r_tmo_cnt == TMO_LAST) begin
            r_state <= IDLE;
            r_err0  <= w_gnt0;
            r_err1  <= w_gnt1;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Slave port mirrors the granted master; everything is 0 in IDLE
  always_comb begin
    w_s_cyc = 1'b0;
    w_s_stb = 1'b0;
    w_s_we  = 1'b0;
    w_s_adr = '0;
    w_s_dat = '0;
    w_s_sel = '0;
    if (w_gnt0) begin
      w_s_cyc = bus.m0_wb_cyc_i;
      w_s_stb = bus.m0_wb_stb_i;
      w_s_we  = bus.m0_wb_we_i;
      w_s_adr = bus.m0_wb_adr_i;
      w_s_dat = bus.m0_wb_dat_i;
      w_s_sel = bus.m0_wb_sel_i;
    end else if (w_gnt1) begin
      w_s_cyc = bus.m1_wb_cyc_i;
      w_s_stb = bus.m1_wb_stb_i;
      w_s_we  = bus.m1_wb_we_i;
      w_s_adr = bus.m1_wb_adr_i;
      w_s_dat = bus.m1_wb_dat_i;
      w_s_sel = bus.m1_wb_sel_i;
    end
  end

  assign bus.s_wb_cyc_o = w_s_cyc;
  assign bus.s_wb_stb_o = w_s_stb;
  assign bus.s_wb_we_o  = w_s_we;
  assign bus.s_wb_adr_o = w_s_adr;
  assign bus.s_wb_dat_o = w_s_dat;
  assign bus.s_wb_sel_o = w_s_sel;

  // ack is steered to the owner only; state is IDLE while reset is high
  assign bus.m0_wb_ack_o = bus.s_wb_ack_i & w_gnt0;
  assign bus.m1_wb_ack_o = bus.s_wb_ack_i & w_gnt1;

  // Read data is broadcast to both masters but held at 0 during reset
  assign bus.m0_wb_dat_o = reset ? '0 : bus.s_wb_dat_i;
  assign bus.m1_wb_dat_o = reset ? '0 : bus.s_wb_dat_i;

`ifdef WB_ARB_TIMEOUT_EN
  assign bus.m0_wb_err_o = r_err0;
  assign bus.m1_wb_err_o = r_err1;
`else
  assign bus.m0_wb_err_o = 1'b0;
  assign bus.m1_wb_err_o = 1'b0;
`endif

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Bench for wb_bus_arbiter.
// It has a fixed vector table, hand-written corner sequences and random
// traffic. Each cycle is checked against a transaction-level reference model.
module tb_wb_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
`ifdef WB_ARB_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif
  localparam logic [AW-1:0] A0 = 32'h1000_0000;
  localparam logic [AW-1:0] A1 = 32'h8000_0100;

  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;

  wb_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  wb_bus_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .o_dbg_state(dbg_state)
  );

  // stimulus variables (index = master number)
  logic          cyc[2];
  logic          stb[2];
  logic          we[2];
  logic [AW-1:0] adr[2];
  logic [DW-1:0] dat[2];
  logic [SW-1:0] sel[2];
  logic          s_ack;
  logic [DW-1:0] s_dat;

  assign bus.m0_wb_cyc_i = cyc[0];
  assign bus.m0_wb_stb_i = stb[0];
  assign bus.m0_wb_we_i  = we[0];
  assign bus.m0_wb_adr_i = adr[0];
  assign bus.m0_wb_dat_i = dat[0];
  assign bus.m0_wb_sel_i = sel[0];
  assign bus.m1_wb_cyc_i = cyc[1];
  assign bus.m1_wb_stb_i = stb[1];
  assign bus.m1_wb_we_i  = we[1];
  assign bus.m1_wb_adr_i = adr[1];
  assign bus.m1_wb_dat_i = dat[1];
  assign bus.m1_wb_sel_i = sel[1];
  assign bus.s_wb_ack_i  = s_ack;
  assign bus.s_wb_dat_i  = s_dat;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: owner -1 = nobody, otherwise master index
  int mdl_owner;
  int mdl_last;
  int mdl_wait;
  bit mdl_err[2];

  typedef struct {
    logic c0;
    logic c1;
    logic ack;
    logic e_cyc;
    int   e_own;
    logic e_ack0;
    logic e_ack1;
  } vec_t;
  vec_t vecs[16];

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mdl_owner  = -1;
    mdl_last   = 1;
    mdl_wait   = 0;
    mdl_err[0] = 1'b0;
    mdl_err[1] = 1'b0;
  endtask

  // Advance the model by one clock using the inputs present at that edge
  task automatic model_step();
    bit nerr[2];
    int w;
    nerr[0] = 1'b0;
    nerr[1] = 1'b0;
    if (mdl_owner < 0) begin
      w = -1;
      if (cyc[0] && cyc[1]) w = 1 - mdl_last;
      else if (cyc[0])      w = 0;
      else if (cyc[1])      w = 1;
      if (w >= 0) begin
        mdl_owner = w;
        mdl_last  = w;
        mdl_wait  = 0;
      end
    end else begin
      if (s_ack || !cyc[mdl_owner]) begin
        mdl_owner = -1;
      end else begin
        mdl_wait++;
`ifdef WB_ARB_TIMEOUT_EN
        if (mdl_wait >= TMO) begin
          nerr[mdl_owner] = 1'b1;
          mdl_owner = -1;
        end
`endif
      end
    end
    mdl_err = nerr;
  endtask

  // Compare every DUT output with what the model says for this cycle
  task automatic check_all();
    logic          e_cyc, e_stb, e_we;
    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_dat, e_rd;
    logic [SW-1:0] e_sel;
    e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0;
    e_adr = '0; e_dat = '0; e_sel = '0;
    if (mdl_owner >= 0) begin
      e_cyc = cyc[mdl_owner];
      e_stb = stb[mdl_owner];
      e_we  = we[mdl_owner];
      e_adr = adr[mdl_owner];
      e_dat = dat[mdl_owner];
      e_sel = sel[mdl_owner];
    end
    e_rd = reset ? '0 : s_dat;
    chk("s_cyc", 64'(bus.s_wb_cyc_o), 64'(e_cyc));
    chk("s_stb", 64'(bus.s_wb_stb_o), 64'(e_stb));
    chk("s_we",  64'(bus.s_wb_we_o),  64'(e_we));
    chk("s_adr", 64'(bus.s_wb_adr_o), 64'(e_adr));
    chk("s_dat", 64'(bus.s_wb_dat_o), 64'(e_dat));
    chk("s_sel", 64'(bus.s_wb_sel_o), 64'(e_sel));
    chk("m0_ack", 64'(bus.m0_wb_ack_o), 64'(s_ack && (mdl_owner == 0)));
    chk("m1_ack", 64'(bus.m1_wb_ack_o), 64'(s_ack && (mdl_owner == 1)));
    chk("m0_err", 64'(bus.m0_wb_err_o), 64'(mdl_err[0]));
    chk("m1_err", 64'(bus.m1_wb_err_o), 64'(mdl_err[1]));
    chk("m0_rdat", 64'(bus.m0_wb_dat_o), 64'(e_rd));
    chk("m1_rdat", 64'(bus.m1_wb_dat_o), 64'(e_rd));
    chk("dbg_busy", 64'(dbg_state != 2'd0), 64'(mdl_owner >= 0));
  endtask

  // One clock: check at the falling edge, advance the model at the rising edge
  task automatic tick();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_fixed();
    adr[0] = A0;            adr[1] = A1;
    we[0]  = 1'b0;          we[1]  = 1'b1;
    dat[0] = 32'h0000_00AA; dat[1] = 32'h5555_0000;
    sel[0] = 4'hF;          sel[1] = 4'h3;
  endtask

  task automatic set_req(input logic c0, input logic c1, input logic ack);
    cyc[0] = c0; stb[0] = c0;
    cyc[1] = c1; stb[1] = c1;
    s_ack  = ack;
    s_dat  = $urandom;
  endtask

  // Mid-cycle asynchronous reset pulse held across one rising edge
  task automatic async_reset_pulse();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin : main
    int  n_ack0, n_ack1;
    logic [AW-1:0] seen_adr;
    logic [AW-1:0] ea;

    // vector table: {c0, c1, ack, exp cyc, exp owner, exp ack0, exp ack1}
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, -1, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b1,  0, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, -1, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b1,  1, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, -1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b1,  0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b1,  0, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, -1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1,  1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0,  1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, -1, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, -1, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b1,  0, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b0, -1, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 1'b1, 1'b1,  1, 1'b0, 1'b1};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0, 1'b0};

    // reset
    reset = 1'b1;
    set_fixed();
    set_req(1'b0, 1'b0, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    check_all();
    chk("reset_s_cyc", 64'(bus.s_wb_cyc_o), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // table: tie after reset goes to m0, then alternation, abort, stray ack
    for (int i = 0; i < 16; i++) begin
      set_req(vecs[i].c0, vecs[i].c1, vecs[i].ack);
      #3;
      ea = (vecs[i].e_own < 0) ? '0 : ((vecs[i].e_own == 0) ? A0 : A1);
      chk($sformatf("vec%0d_cyc", i), 64'(bus.s_wb_cyc_o), 64'(vecs[i].e_cyc));
      chk($sformatf("vec%0d_adr", i), 64'(bus.s_wb_adr_o), 64'(ea));
      chk($sformatf("vec%0d_we", i),  64'(bus.s_wb_we_o),  64'(vecs[i].e_own == 1));
      chk($sformatf("vec%0d_ack0", i), 64'(bus.m0_wb_ack_o), 64'(vecs[i].e_ack0));
      chk($sformatf("vec%0d_ack1", i), 64'(bus.m1_wb_ack_o), 64'(vecs[i].e_ack1));
      tick();
    end

    // m1-only write, slave acks on the third granted cycle
    n_ack0 = 0;
    n_ack1 = 0;
    seen_adr = '0;
    for (int k = 0; k < 7; k++) begin
      set_req(1'b0, (k <= 3), (k == 3));
      #3;
      if (k == 1) seen_adr = bus.s_wb_adr_o;
      if (bus.m0_wb_ack_o) n_ack0++;
      if (bus.m1_wb_ack_o) n_ack1++;
      tick();
    end
    chk("m1_only_adr", 64'(seen_adr), 64'(A1));
    chk("m1_only_ack1_pulses", 64'(n_ack1), 64'd1);
    chk("m1_only_ack0_pulses", 64'(n_ack0), 64'd0);

    // reset in the middle of an m0 transfer, then a tie must go to m0 again
    set_req(1'b1, 1'b0, 1'b0);
    tick();
    #1;
    chk("pre_reset_cyc", 64'(bus.s_wb_cyc_o), 64'd1);
    s_ack = 1'b1;
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    chk("mid_reset_cyc", 64'(bus.s_wb_cyc_o), 64'd0);
    chk("mid_reset_ack0", 64'(bus.m0_wb_ack_o), 64'd0);
    chk("mid_reset_rdat", 64'(bus.m0_wb_dat_o), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    set_req(1'b1, 1'b1, 1'b0);
    tick();
    #3;
    chk("regrant_m0_adr", 64'(bus.s_wb_adr_o), 64'(A0));
    tick();
    set_req(1'b1, 1'b1, 1'b1);
    tick();
    set_req(1'b0, 1'b0, 1'b0);
    tick();

`ifdef WB_ARB_TIMEOUT_EN
    // m0 never acked: four granted cycles, then an err pulse with cyc low
    for (int k = 0; k < 7; k++) begin
      set_req(1'b1, 1'b0, 1'b0);
      #3;
      chk($sformatf("tmo%0d_cyc", k), 64'(bus.s_wb_cyc_o), 64'((k >= 1 && k <= 4) || k == 6));
      chk($sformatf("tmo%0d_err0", k), 64'(bus.m0_wb_err_o), 64'(k == 5));
      tick();
    end
    set_req(1'b0, 1'b0, 1'b0);
    tick();
    tick();
`endif

    // random traffic with occasional asynchronous resets
    for (int n = 0; n < 1500; n++) begin
      for (int m = 0; m < 2; m++) begin
        cyc[m] = ($urandom_range(0, 3) != 0);
        stb[m] = ($urandom_range(0, 3) != 0);
        we[m]  = 1'($urandom_range(0, 1));
        adr[m] = $urandom;
        dat[m] = $urandom;
        sel[m] = 4'($urandom_range(0, 15));
      end
      s_ack = ($urandom_range(0, 2) == 0);
      s_dat = $urandom;
      if ($urandom_range(0, 199) == 0) async_reset_pulse();
      else tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
